// File: rtl/biquad_seq_if.sv
// biquad_seq_if: sample strobe, coefficient ROM link and output bundle of the biquad sequencer.
interface biquad_seq_if #(parameter int cant_bits = 25);
  logic                 start;
  logic                 clr_hist;
  logic [cant_bits-1:0] x_in;
  logic [3:0]           sel_cte;
  logic [cant_bits-1:0] cte;
  logic [cant_bits-1:0] y_out;
  logic                 done;
  logic                 busy;
  modport master (output start, clr_hist, x_in, cte, input sel_cte, y_out, done, busy);
  modport slave (input start, clr_hist, x_in, cte, output sel_cte, y_out, done, busy);
endinterface

// File: rtl/biquad_seq.sv
// biquad_seq: one-MAC sequencer for a second-order IIR section, fetching coefficients from the constant mux.
module biquad_seq #(
  parameter int cant_bits = 25,
  parameter int frac_bits = 14
) (
  input logic clk,
  input logic reset,
  biquad_seq_if.slave bus
);
  typedef enum logic [2:0] {IDLE, B0, B1, B2, A1, A2, G, UPD} state_t;
  localparam int aw = cant_bits + 4;
  localparam int pw = 2 * cant_bits;
  localparam logic signed [pw:0] acc_hi = {{(pw - aw + 2){1'b0}}, {(aw - 1){1'b1}}};
  localparam logic signed [pw:0] acc_lo = ~acc_hi;
  localparam logic signed [pw:0] smp_hi = {{(pw - cant_bits + 2){1'b0}}, {(cant_bits - 1){1'b1}}};
  localparam logic signed [pw:0] smp_lo = ~smp_hi;
  state_t state, state_nx;
  logic signed [cant_bits-1:0] x, x1, x2, y1, y2, op, acc_s, y;
  logic signed [aw-1:0] acc, acc_nx;
  logic signed [pw-1:0] prod;
  logic signed [pw:0] acc_x, term, sum;
  logic [3:0] sel_nx;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE ? (bus.start ? B0 : IDLE) : state == UPD ? IDLE : state_t'(state + 3'd1);
    sel_nx = state_nx == B0 ? 4'd5 : state_nx == B1 ? 4'd6 : state_nx == B2 ? 4'd7 :
             state_nx == A1 ? 4'd1 : state_nx == A2 ? 4'd2 : 4'd0;
  end
  // Single multiplier: the operand follows the state, the coefficient arrives from the ROM in the same cycle.
  always_comb begin
    op = state == B0 ? x : state == B1 ? x1 : state == B2 ? x2 :
         state == A1 ? y1 : state == A2 ? y2 : acc_s;
    prod = pw'(op) * pw'($signed(bus.cte));
    term = $signed({prod[pw-1], prod}) >>> frac_bits;
    acc_x = (pw + 1)'(acc);
    sum = (state == B0 ? {(pw + 1){1'b0}} : acc_x) + term;
    acc_nx = sum > acc_hi ? acc_hi[aw-1:0] : sum < acc_lo ? acc_lo[aw-1:0] : sum[aw-1:0];
    acc_s = acc_x > smp_hi ? smp_hi[cant_bits-1:0] : acc_x < smp_lo ? smp_lo[cant_bits-1:0] : acc[cant_bits-1:0];
    y = term > smp_hi ? smp_hi[cant_bits-1:0] : term < smp_lo ? smp_lo[cant_bits-1:0] : term[cant_bits-1:0];
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      bus.sel_cte <= '0;
      bus.y_out <= '0;
      acc <= '0;
      x <= '0;
      x1 <= '0;
      x2 <= '0;
      y1 <= '0;
      y2 <= '0;
    end else begin
      bus.sel_cte <= sel_nx;
      if (state == IDLE && bus.start) x <= bus.x_in;
      if (state >= B0 && state <= A2) acc <= acc_nx;
      if (state == IDLE && bus.clr_hist) begin
        x1 <= '0;
        x2 <= '0;
        y1 <= '0;
        y2 <= '0;
      end
      if (state == G) begin
        bus.y_out <= y;
        x2 <= x1;
        x1 <= x;
        y2 <= y1;
        y1 <= y;
      end
    end
  assign bus.done = state == UPD;
  assign bus.busy = state != IDLE;
endmodule
